// File: rtl/shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : shift_pipe
// Brief    : Pipelined barrel shifter (SLL/SRL/SRA/ROR), one shift level per stage
// Revision : 1.0
// ============================================================================
module shift_pipe #(
   parameter  int WIDTH = 32,
   parameter  int TAGW  = 5,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic [SHW-1:0]   in_shamt_i,
   input  logic [1:0]       in_op_i,
   input  logic [TAGW-1:0]  in_tag_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_data_o,
   output logic [TAGW-1:0]  out_tag_o,
   output logic [SHW:0]     occupancy_o
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRL = 2'b01;
   localparam logic [1:0] OP_SRA = 2'b10;
   localparam logic [1:0] OP_ROR = 2'b11;

   logic             adv;
   logic             accept;

   logic [SHW-1:0]   valid_q;
   logic [SHW-1:0]   valid_d;
   logic [WIDTH-1:0] data_q    [SHW];
   logic [WIDTH-1:0] data_d    [SHW];
   logic [SHW-1:0]   shamt_q   [SHW];
   logic [SHW-1:0]   shamt_src [SHW];
   logic [1:0]       op_q      [SHW];
   logic [1:0]       op_src    [SHW];
   logic [TAGW-1:0]  tag_q     [SHW];
   logic [TAGW-1:0]  tag_src   [SHW];
   logic [SHW:0]     occ_q;
   logic [SHW:0]     occ_d;

   // The whole pipe moves as one; a stalled output freezes every stage.
   assign adv        = !valid_q[SHW-1] || out_ready_i;
   assign in_ready_o = adv && !flush_i;
   assign accept     = in_valid_i && in_ready_o;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int AMT = 1 << (SHW - 1 - k);

      logic             src_valid;
      logic [WIDTH-1:0] src_data;
      logic [WIDTH-1:0] sll;
      logic [WIDTH-1:0] srl;
      logic [WIDTH-1:0] sra;
      logic [WIDTH-1:0] ror;
      logic [WIDTH-1:0] next_data;

      if (k == 0) begin : g_head
         assign src_valid    = accept;
         assign src_data     = in_data_i;
         assign shamt_src[k] = in_shamt_i;
         assign op_src[k]    = in_op_i;
         assign tag_src[k]   = in_tag_i;
      end else begin : g_body
         assign src_valid    = valid_q[k-1];
         assign src_data     = data_q[k-1];
         assign shamt_src[k] = shamt_q[k-1];
         assign op_src[k]    = op_q[k-1];
         assign tag_src[k]   = tag_q[k-1];
      end

      assign sll = {src_data[WIDTH-1-AMT:0], {AMT{1'b0}}};
      assign srl = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
      // The operand sign survives every earlier stage, so the current MSB is the fill bit.
      assign sra = {{AMT{src_data[WIDTH-1]}}, src_data[WIDTH-1:AMT]};
      assign ror = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};

      always_comb begin
         next_data = src_data;
         if (shamt_src[k][SHW-1-k]) begin
            case (op_src[k])
               OP_SLL:  next_data = sll;
               OP_SRL:  next_data = srl;
               OP_SRA:  next_data = sra;
               OP_ROR:  next_data = ror;
               default: next_data = src_data;
            endcase
         end
      end

      assign data_d[k]  = next_data;
      assign valid_d[k] = flush_i ? 1'b0 : (adv ? src_valid : valid_q[k]);
   end

   always_comb begin
      occ_d = '0;
      for (int k = 0; k < SHW; k++) begin
         occ_d = occ_d + {{SHW{1'b0}}, valid_d[k]};
      end
   end

   always_ff @(posedge clock_i) begin
      if (!reset_ni) begin
         valid_q <= '0;
         occ_q   <= '0;
         for (int k = 0; k < SHW; k++) begin
            data_q[k]  <= '0;
            shamt_q[k] <= '0;
            op_q[k]    <= '0;
            tag_q[k]   <= '0;
         end
      end else begin
         valid_q <= valid_d;
         occ_q   <= occ_d;
         if (adv) begin
            for (int k = 0; k < SHW; k++) begin
               data_q[k]  <= data_d[k];
               shamt_q[k] <= shamt_src[k];
               op_q[k]    <= op_src[k];
               tag_q[k]   <= tag_src[k];
            end
         end
      end
   end

   assign out_valid_o = valid_q[SHW-1];
   assign out_data_o  = data_q[SHW-1];
   assign out_tag_o   = tag_q[SHW-1];
   assign occupancy_o = occ_q;

endmodule
`default_nettype wire

// File: tb/tb_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_pipe
// Brief    : Scoreboard bench for shift_pipe (WIDTH=32, TAGW=5)
// Revision : 1.0
// ============================================================================
module tb_shift_pipe;

   localparam int WIDTH = 32;
   localparam int TAGW  = 5;
   localparam int SHW   = 5;
   localparam int LAT   = 5;

   logic             clock = 1'b0;
   logic             reset_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [SHW-1:0]   in_shamt;
   logic [1:0]       in_op;
   logic [TAGW-1:0]  in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [TAGW-1:0]  out_tag;
   logic [SHW:0]     occupancy;

   always #5 clock = ~clock;

   shift_pipe #(.WIDTH(WIDTH), .TAGW(TAGW)) dut (
      .clock_i     (clock),
      .reset_ni    (reset_n),
      .flush_i     (flush),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .in_shamt_i  (in_shamt),
      .in_op_i     (in_op),
      .in_tag_i    (in_tag),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_tag_o   (out_tag),
      .occupancy_o (occupancy)
   );

   typedef struct {
      logic [WIDTH-1:0] data;
      logic [TAGW-1:0]  tag;
      int               cyc;
      int               stl;
   } exp_t;

   exp_t             sb[$];
   exp_t             pop_e;
   int               checks = 0;
   int               errors = 0;
   int               cyc    = 0;
   int               stalls = 0;
   int               peak   = 0;
   logic             stall_run = 1'b0;
   logic [WIDTH-1:0] held_data;
   logic [TAGW-1:0]  held_tag;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int s,
                                              input logic [1:0] op);
      logic [2*WIDTH-1:0] dd;
      case (op)
         2'b00:   return d << s;
         2'b01:   return d >> s;
         2'b10:   return WIDTH'($signed(d) >>> s);
         default: begin
            dd = {d, d} >> s;
            return dd[WIDTH-1:0];
         end
      endcase
   endfunction

   // Observer: everything sampled mid-cycle, the handshakes seen here complete at the next edge.
   always @(negedge clock) begin
      if (!reset_n) begin
         sb.delete();
         stall_run = 1'b0;
      end else begin
         cyc++;
         check("occupancy", 32'(occupancy), 32'(sb.size()));
         if (int'(occupancy) > peak) peak = int'(occupancy);
         if (sb.size() != 0 && (cyc - sb[0].cyc - (stalls - sb[0].stl)) == LAT)
            check("due_valid", 32'(out_valid), 32'd1);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
               pop_e = sb.pop_front();
               check("out_data", out_data, pop_e.data);
               check("out_tag", 32'(out_tag), 32'(pop_e.tag));
               check("latency", 32'(cyc - pop_e.cyc - (stalls - pop_e.stl)), 32'(LAT));
            end
         end
         if (stall_run && !out_ready) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, held_data);
            check("hold_tag", 32'(out_tag), 32'(held_tag));
         end
         if (out_valid && !out_ready) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            held_data = out_data;
            held_tag  = out_tag;
            stall_run = 1'b1;
            stalls++;
         end else begin
            stall_run = 1'b0;
         end
         if (flush) begin
            sb.delete();
         end else if (in_valid && in_ready) begin
            sb.push_back('{data: model(in_data, int'(in_shamt), in_op),
                           tag: in_tag, cyc: cyc, stl: stalls});
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic issue(input logic [WIDTH-1:0] d, input int s, input int op, input int tag);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_shamt = SHW'(s);
      in_op    = 2'(op);
      in_tag   = TAGW'(tag);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clock);
         ok = in_ready;
         @(posedge clock);
         #2;
      end
      if (!ok) check("issue_timeout", 32'(ok), 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() != 0; i++) tick(1);
      tick(2);
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_idle(input string where);
      @(negedge clock);
      check({where, "_out_valid"}, 32'(out_valid), 32'd0);
      check({where, "_out_data"}, out_data, 32'd0);
      check({where, "_out_tag"}, 32'(out_tag), 32'd0);
      check({where, "_occupancy"}, 32'(occupancy), 32'd0);
      check({where, "_in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clock);
      #2;
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shamt  = '0;
      in_op     = '0;
      in_tag    = '0;
      out_ready = 1'b1;
      tick(3);
      reset_n = 1'b1;
      check_idle("reset");

      // Basic ops on 0x8000_00F0 by 4
      for (int op = 0; op < 4; op++) issue(32'h8000_00F0, 4, op, op + 1);
      drain();

      // Boundaries
      for (int op = 0; op < 4; op++) issue(32'hDEAD_BEEF, 0, op, op + 4);
      issue(32'h0000_0001, 31, 0, 8);
      issue(32'h8000_0000, 31, 2, 9);
      issue(32'h0000_0001, 31, 3, 10);
      drain();

      // Back-to-back, tags 0..7
      peak = 0;
      for (int t = 0; t < 8; t++) issue($urandom(), $urandom_range(0, 31), $urandom_range(0, 3), t);
      drain();
      check("b2b_peak_occupancy", 32'(peak), 32'd5);

      // Backpressure on a full pipe
      fork
         for (int t = 8; t < 16; t++) issue($urandom(), $urandom_range(0, 31), $urandom_range(0, 3), t);
         begin
            tick(5);
            out_ready = 1'b0;
            tick(3);
            out_ready = 1'b1;
         end
      join
      drain();

      // Flush with a simultaneous offer
      for (int t = 20; t < 23; t++) issue($urandom(), $urandom_range(0, 31), $urandom_range(0, 3), t);
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      in_tag   = TAGW'(23);
      flush    = 1'b1;
      tick(1);
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check("flush_out_valid", 32'(out_valid), 32'd0);
      check("flush_occupancy", 32'(occupancy), 32'd0);
      tick(1);
      tick(10);
      issue(32'h0000_00FF, 8, 0, 24);
      drain();

      // Reset with operations in flight
      for (int t = 25; t < 29; t++) issue($urandom(), $urandom_range(0, 31), $urandom_range(0, 3), t);
      reset_n = 1'b0;
      tick(1);
      reset_n = 1'b1;
      check_idle("midreset");
      issue(32'h0000_0001, 1, 0, 29);
      drain();

      // Random traffic with random backpressure
      fork
         for (int t = 0; t < 30; t++) issue($urandom(), $urandom_range(0, 31), $urandom_range(0, 3), t);
         begin
            for (int i = 0; i < 60; i++) begin
               out_ready = 1'($urandom_range(0, 1));
               tick(1);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
